// File: rtl/wb_switch_pkg.sv
// Shared state encoding and address-decode helpers for the Wishbone 1:N switch.
package wb_switch_pkg;

  typedef enum logic {ST_IDLE = 1'b0, ST_ACTIVE = 1'b1} state_t;

  localparam int IDX_W = 4;
  localparam logic [IDX_W-1:0] MISS_IDX = 4'd8;

  // Operands are zero-extended to 64 bits so one helper serves any AW up to 64.
  function automatic logic [1:0] hit_vec(input logic [63:0] adr,
                                         input logic [63:0] base1,
                                         input logic [63:0] mask1,
                                         input logic [63:0] base2,
                                         input logic [63:0] mask2,
                                         input logic        win2_off);
    logic [1:0] h;
    h[0] = (adr & mask1) == (base1 & mask1);
    h[1] = !win2_off && ((adr & mask2) == (base2 & mask2));
    return h;
  endfunction

  function automatic logic [IDX_W-1:0] prio_enc(input logic [7:0] hits);
    logic [IDX_W-1:0] idx;
    idx = MISS_IDX;
    for (int i = 7; i >= 0; i--)
      if (hits[i]) idx = IDX_W'(i);
    return idx;
  endfunction

endpackage

// File: rtl/wb_switch_nport_watchdog.sv
// Per-access bus watchdog: cycle counter, expiry compare and sticky timeout diagnostics.
module wb_bus_watchdog #(
  parameter int AW         = 32,
  parameter int TMO_CYCLES = 255
) (
  input  logic          clk,
  input  logic          rst_b,
  input  logic          active,
  input  logic          fire,
  input  logic [AW-1:0] adr,
  input  logic          clr,
  output logic          expire,
  output logic          flag,
  output logic [AW-1:0] flag_adr
);

  localparam int CW = (TMO_CYCLES > 255) ? 16 : 8;

  logic [CW-1:0] cnt;

  // Counter restarts whenever the switch leaves ACTIVE, so each access gets a fresh budget.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b)      cnt <= '0;
    else if (active) cnt <= cnt + CW'(1);
    else             cnt <= '0;
  end

  assign expire = (TMO_CYCLES != 0) && active && (cnt == CW'(TMO_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      flag     <= 1'b0;
      flag_adr <= '0;
    end else begin
      if (clr)       flag <= 1'b0;
      else if (fire) flag <= 1'b1;
      if (fire && !flag) flag_adr <= adr;
    end
  end

endmodule

// File: rtl/wb_switch_nport.sv
// Wishbone classic 1-master/N-slave decoder and switch with default slave and bus watchdog.
//   state     | meaning
//   ST_IDLE   | no access in flight; decode a new cycle on cyc & stb
//   ST_ACTIVE | access routed to slave sel (or MISS); wait for ack/err/timeout/abort
module wb_switch_nport
  import wb_switch_pkg::*;
#(
  parameter int                   NSLAVE     = 4,
  parameter int                   AW         = 32,
  parameter int                   DW         = 32,
  parameter logic [NSLAVE*AW-1:0] S_ADDR1    = '0,
  parameter logic [NSLAVE*AW-1:0] S_MASK1    = '1,
  parameter logic [NSLAVE*AW-1:0] S_ADDR2    = '1,
  parameter logic [NSLAVE*AW-1:0] S_MASK2    = '1,
  parameter bit                   MISS_ERR   = 1'b0,
  parameter logic [DW-1:0]        DEF_DATA   = {(DW/8){8'haa}},
  parameter int                   TMO_CYCLES = 255
) (
  input  logic                 clk,
  input  logic                 rst_b,
  input  logic [AW-1:0]        m_adr_i,
  input  logic [DW-1:0]        m_dat_i,
  input  logic [DW/8-1:0]      m_sel_i,
  input  logic                 m_we_i,
  input  logic                 m_cyc_i,
  input  logic                 m_stb_i,
  output logic [DW-1:0]        m_dat_o,
  output logic                 m_ack_o,
  output logic                 m_err_o,
  output logic [AW-1:0]        s_adr_o,
  output logic [DW-1:0]        s_dat_o,
  output logic [DW/8-1:0]      s_sel_o,
  output logic                 s_we_o,
  output logic [NSLAVE-1:0]    s_cyc_o,
  output logic [NSLAVE-1:0]    s_stb_o,
  input  logic [NSLAVE*DW-1:0] s_dat_i,
  input  logic [NSLAVE-1:0]    s_ack_i,
  input  logic [NSLAVE-1:0]    s_err_i,
  output logic                 tmo_flag_o,
  output logic [AW-1:0]        tmo_adr_o,
  input  logic                 tmo_clr_i
);

  state_t           state;
  logic [IDX_W-1:0] sel;
  logic [7:0]       hits;
  logic             active, miss, slv, sel_ack, sel_err, expire, tmo_fire;
  logic [DW-1:0]    sel_dat;

  assign s_adr_o = m_adr_i;
  assign s_dat_o = m_dat_i;
  assign s_sel_o = m_sel_i;
  assign s_we_o  = m_we_i;

  always_comb begin
    hits = '0;
    for (int k = 0; k < NSLAVE; k++)
      hits[k] = |hit_vec(64'(m_adr_i),
                         64'(S_ADDR1[k*AW +: AW]), 64'(S_MASK1[k*AW +: AW]),
                         64'(S_ADDR2[k*AW +: AW]), 64'(S_MASK2[k*AW +: AW]),
                         (&S_MASK2[k*AW +: AW]) && (&S_ADDR2[k*AW +: AW]));
  end

  always_comb begin
    sel_ack = 1'b0;
    sel_err = 1'b0;
    sel_dat = '0;
    for (int k = 0; k < NSLAVE; k++)
      if (sel == IDX_W'(k)) begin
        sel_ack = s_ack_i[k];
        sel_err = s_err_i[k];
        sel_dat = s_dat_i[k*DW +: DW];
      end
  end

  assign active   = (state == ST_ACTIVE);
  assign miss     = (sel == MISS_IDX);
  assign slv      = active && !miss && m_cyc_i;
  assign tmo_fire = slv && expire && !sel_ack && !sel_err;

  always_comb begin
    s_cyc_o = '0;
    s_stb_o = '0;
    if (slv && !tmo_fire)
      for (int k = 0; k < NSLAVE; k++)
        if (sel == IDX_W'(k)) begin
          s_cyc_o[k] = m_cyc_i;
          s_stb_o[k] = m_stb_i;
        end
  end

  // A slave raising ack and err together is reported as an error only.
  assign m_ack_o = (slv && sel_ack && !sel_err) || (active && miss && m_cyc_i && !MISS_ERR);
  assign m_err_o = (slv && sel_err) || tmo_fire || (active && miss && m_cyc_i && MISS_ERR);
  assign m_dat_o = (active && miss) ? DEF_DATA : (slv ? sel_dat : '0);

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state <= ST_IDLE;
      sel   <= MISS_IDX;
    end else begin
      case (state)
        ST_IDLE:
          if (m_cyc_i && m_stb_i) begin
            sel   <= prio_enc(hits);
            state <= ST_ACTIVE;
          end
        ST_ACTIVE:
          if (!m_cyc_i || miss || sel_ack || sel_err || expire) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  wb_bus_watchdog #(.AW(AW), .TMO_CYCLES(TMO_CYCLES)) u_wdog (
    .clk      (clk),
    .rst_b    (rst_b),
    .active   (active),
    .fire     (tmo_fire),
    .adr      (m_adr_i),
    .clr      (tmo_clr_i),
    .expire   (expire),
    .flag     (tmo_flag_o),
    .flag_adr (tmo_adr_o)
  );

endmodule

// File: tb/tb_wb_switch_nport.sv
// Randomized bench for wb_switch_nport: 3-slave map (ROM, tube, RAM), miss handling and watchdog.
module tb_wb_switch_nport;

  localparam int NS  = 3;
  localparam int TMO = 16;

  // Memory map: slave 0 ROM (boot alias at 0 + 0x03xxxxxx), slave 1 tube, slave 2 RAM.
  localparam logic [31:0] MB1 [NS] = '{32'h0000_0000, 32'h0100_0000, 32'h0000_0000};
  localparam logic [31:0] MM1 [NS] = '{32'hFFFF_F000, 32'hFF00_0000, 32'hFFE0_0000};
  localparam logic [31:0] MB2 [NS] = '{32'h0300_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
  localparam logic [31:0] MM2 [NS] = '{32'hFF00_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};

  localparam logic [NS*32-1:0] P_ADDR1 = {MB1[2], MB1[1], MB1[0]};
  localparam logic [NS*32-1:0] P_MASK1 = {MM1[2], MM1[1], MM1[0]};
  localparam logic [NS*32-1:0] P_ADDR2 = {MB2[2], MB2[1], MB2[0]};
  localparam logic [NS*32-1:0] P_MASK2 = {MM2[2], MM2[1], MM2[0]};

  logic           clk, rst_b;
  logic [31:0]    m_adr_i, m_dat_i;
  logic [3:0]     m_sel_i;
  logic           m_we_i, m_cyc_i, m_stb_i, tmo_clr_i;
  logic [NS-1:0]  s_ack_i, s_err_i;
  logic [31:0]    sdat [NS];
  logic [NS*32-1:0] s_dat_i;

  logic [31:0]    m_dat_o, s_adr_o, s_dat_o, tmo_adr_o;
  logic           m_ack_o, m_err_o, s_we_o, tmo_flag_o;
  logic [3:0]     s_sel_o;
  logic [NS-1:0]  s_cyc_o, s_stb_o;

  logic [31:0]    me_dat, me_s_adr, me_s_dat, me_tmo_adr;
  logic           me_ack, me_err, me_s_we, me_tmo_flag;
  logic [3:0]     me_s_sel;
  logic [NS-1:0]  me_cyc, me_stb;

  assign s_dat_i = {sdat[2], sdat[1], sdat[0]};

  wb_switch_nport #(
    .NSLAVE(NS), .AW(32), .DW(32),
    .S_ADDR1(P_ADDR1), .S_MASK1(P_MASK1), .S_ADDR2(P_ADDR2), .S_MASK2(P_MASK2),
    .MISS_ERR(1'b0), .DEF_DATA(32'haaaaaaaa), .TMO_CYCLES(TMO)
  ) u_dut (
    .clk(clk), .rst_b(rst_b),
    .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_sel_i(m_sel_i), .m_we_i(m_we_i),
    .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i),
    .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_we_o(s_we_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i),
    .tmo_flag_o(tmo_flag_o), .tmo_adr_o(tmo_adr_o), .tmo_clr_i(tmo_clr_i)
  );

  wb_switch_nport #(
    .NSLAVE(NS), .AW(32), .DW(32),
    .S_ADDR1(P_ADDR1), .S_MASK1(P_MASK1), .S_ADDR2(P_ADDR2), .S_MASK2(P_MASK2),
    .MISS_ERR(1'b1), .DEF_DATA(32'haaaaaaaa), .TMO_CYCLES(TMO)
  ) u_dut_me (
    .clk(clk), .rst_b(rst_b),
    .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_sel_i(m_sel_i), .m_we_i(m_we_i),
    .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i),
    .m_dat_o(me_dat), .m_ack_o(me_ack), .m_err_o(me_err),
    .s_adr_o(me_s_adr), .s_dat_o(me_s_dat), .s_sel_o(me_s_sel), .s_we_o(me_s_we),
    .s_cyc_o(me_cyc), .s_stb_o(me_stb),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i),
    .tmo_flag_o(me_tmo_flag), .tmo_adr_o(me_tmo_adr), .tmo_clr_i(tmo_clr_i)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_chk = 0;
  int n_err = 0;
  logic        exp_flag = 1'b0;
  logic [31:0] exp_adr  = '0;
  bit          clr_on_tmo = 1'b0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference decode: first slave (lowest index) with a matching enabled window.
  function automatic int exp_slave(input logic [31:0] a);
    for (int k = 0; k < NS; k++) begin
      if ((a & MM1[k]) == (MB1[k] & MM1[k])) return k;
      if (!(MM2[k] == 32'hFFFF_FFFF && MB2[k] == 32'hFFFF_FFFF) &&
          (a & MM2[k]) == (MB2[k] & MM2[k])) return k;
    end
    return -1;
  endfunction

  // lat: ACTIVE cycle in which the slave responds (0 = never); rtype: 0 ack, 1 err, 2 ack+err.
  task automatic do_access(input logic [31:0] adr, input int lat, input int rtype);
    int k, c;
    bit done;
    logic [NS-1:0] oh;
    k = exp_slave(adr);
    oh = (k >= 0) ? NS'(1 << k) : '0;
    for (int i = 0; i < NS; i++) sdat[i] = $urandom;
    @(negedge clk);
    m_adr_i = adr; m_dat_i = $urandom; m_we_i = 1'($urandom_range(0, 1));
    m_sel_i = 4'hF; m_cyc_i = 1'b1; m_stb_i = 1'b1;
    #1 chk("idle_stb", s_stb_o, 0);
    done = 1'b0;
    c = 0;
    while (!done && c < 40) begin
      @(posedge clk); #1; c++;
      if (k < 0) begin
        chk("miss_cyc", s_cyc_o, 0);
        chk("miss_ack", m_ack_o, 1);
        chk("miss_err", m_err_o, 0);
        chk("miss_dat", m_dat_o, 32'haaaaaaaa);
        chk("me_miss_err", me_err, 1);
        chk("me_miss_ack", me_ack, 0);
        chk("me_miss_cyc", me_cyc, 0);
        done = 1'b1;
      end else begin
        if (c < TMO) chk("stb", s_stb_o, oh);
        if (c == lat) begin
          case (rtype)
            0:       s_ack_i[k] = 1'b1;
            1:       s_err_i[k] = 1'b1;
            default: begin s_ack_i[k] = 1'b1; s_err_i[k] = 1'b1; end
          endcase
          #1;
          chk("rsp_stb", s_stb_o, oh);
          chk("rsp_ack", m_ack_o, rtype == 0);
          chk("rsp_err", m_err_o, rtype != 0);
          if (rtype == 0) chk("rsp_dat", m_dat_o, sdat[k]);
          chk("me_rsp_ack", me_ack, rtype == 0);
          chk("me_rsp_err", me_err, rtype != 0);
          done = 1'b1;
        end else if (c == TMO) begin
          if (clr_on_tmo) tmo_clr_i = 1'b1;
          #1;
          chk("tmo_err", m_err_o, 1);
          chk("tmo_ack", m_ack_o, 0);
          chk("tmo_stb", s_stb_o, 0);
          chk("me_tmo_err", me_err, 1);
          if (!exp_flag) exp_adr = adr;
          exp_flag = !clr_on_tmo;
          done = 1'b1;
        end else begin
          #1;
          chk("wait_ack", m_ack_o, 0);
          chk("wait_err", m_err_o, 0);
        end
      end
    end
    if (!done) chk("resp_bound", 0, 1);
    @(posedge clk); #1;
    chk("back_idle_stb", s_stb_o, 0);
    m_cyc_i = 1'b0; m_stb_i = 1'b0; s_ack_i = '0; s_err_i = '0; tmo_clr_i = 1'b0;
    chk("tmo_flag", tmo_flag_o, exp_flag);
    chk("tmo_adr", tmo_adr_o, exp_adr);
  endtask

  task automatic pulse_clr();
    @(negedge clk); tmo_clr_i = 1'b1;
    @(posedge clk); #1;
    tmo_clr_i = 1'b0;
    exp_flag = 1'b0;
    chk("clr_flag", tmo_flag_o, 0);
    chk("clr_adr", tmo_adr_o, exp_adr);
  endtask

  initial begin
    int r, lat, rt;
    logic [31:0] a;
    rst_b = 1'b0; m_adr_i = 32'h1234_5678; m_dat_i = 32'hCAFE_0001; m_sel_i = 4'h5;
    m_we_i = 1'b1; m_cyc_i = 1'b0; m_stb_i = 1'b0; tmo_clr_i = 1'b0;
    s_ack_i = '0; s_err_i = '0;
    for (int i = 0; i < NS; i++) sdat[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ack", m_ack_o, 0);
    chk("rst_err", m_err_o, 0);
    chk("rst_dat", m_dat_o, 0);
    chk("rst_cyc", s_cyc_o, 0);
    chk("rst_flag", tmo_flag_o, 0);
    chk("rst_tmo_adr", tmo_adr_o, 0);
    chk("bcast_adr", s_adr_o, 32'h1234_5678);
    chk("bcast_dat", s_dat_o, 32'hCAFE_0001);
    chk("bcast_sel", s_sel_o, 4'h5);
    chk("bcast_we", s_we_o, 1);
    @(negedge clk); rst_b = 1'b1;

    do_access(32'h0100_0004, 2, 0);
    do_access(32'h0000_0000, 1, 0);
    do_access(32'h0200_0000, 1, 0);
    do_access(32'hFFFF_FFFF, 1, 0);
    do_access(32'h0300_0100, 3, 1);
    do_access(32'h0000_8000, 2, 2);
    do_access(32'h0100_0010, 0, 0);
    do_access(32'h0000_2000, 0, 0);
    pulse_clr();
    do_access(32'h0100_0020, TMO, 0);
    clr_on_tmo = 1'b1;
    do_access(32'h0000_3000, 0, 0);
    clr_on_tmo = 1'b0;

    for (int n = 0; n < 60; n++) begin
      r = $urandom_range(0, 4);
      case (r)
        0:       a = $urandom & 32'h0000_0FFF;
        1:       a = 32'h0100_0000 | ($urandom & 32'h00FF_FFFF);
        2:       a = 32'h0000_1000 + ($urandom % 32'h001F_F000);
        3:       a = 32'h0300_0000 | ($urandom & 32'h00FF_FFFF);
        default: a = {8'($urandom_range(4, 255)), 24'($urandom)};
      endcase
      lat = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 6);
      rt  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0;
      do_access(a, lat, rt);
      if ($urandom_range(0, 7) == 0) pulse_clr();
    end

    // Master abort mid-access
    @(negedge clk);
    m_adr_i = 32'h0100_0040; m_cyc_i = 1'b1; m_stb_i = 1'b1;
    repeat (3) @(posedge clk);
    #1 chk("abort_pre_stb", s_stb_o, 3'b010);
    @(negedge clk); m_cyc_i = 1'b0; m_stb_i = 1'b0;
    #1 chk("abort_cyc", s_cyc_o, 0);
    repeat (20) begin
      @(posedge clk); #1;
      chk("abort_ack", m_ack_o, 0);
      chk("abort_err", m_err_o, 0);
    end
    chk("abort_flag", tmo_flag_o, exp_flag);
    do_access(32'h0100_0044, 12, 0);

    // Async reset mid-access with the sticky flag set
    do_access(32'h0100_0050, 0, 0);
    @(negedge clk);
    m_adr_i = 32'h0000_4000; m_cyc_i = 1'b1; m_stb_i = 1'b1;
    repeat (4) @(posedge clk);
    #3 chk("pre_rst_stb", s_stb_o, 3'b100);
    rst_b = 1'b0;
    #1;
    chk("arst_stb", s_stb_o, 0);
    chk("arst_cyc", s_cyc_o, 0);
    chk("arst_ack", m_ack_o, 0);
    chk("arst_err", m_err_o, 0);
    chk("arst_flag", tmo_flag_o, 0);
    chk("arst_adr", tmo_adr_o, 0);
    exp_flag = 1'b0; exp_adr = '0;
    @(negedge clk); m_cyc_i = 1'b0; m_stb_i = 1'b0;
    @(negedge clk); rst_b = 1'b1;
    do_access(32'h0000_4000, 2, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
